modport_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 18 +
 rtl/modport_counter_next.sv | 42 ++++
 rtl/modport_counter.sv | 41 ++++
 tb/tb_modport_counter.sv | 116 +++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants, count type and legality helper for the
// modulo up/down counter. The modulus sets the count range 0..MOD-1, the
// width covers data_in and count, count_t is the count value type, and
// legal() is 1 when a value lies inside the count range.
package counter_pkg;

  localparam int MOD   = 12;
  localparam int WIDTH = 4;

  typedef logic [WIDTH-1:0] count_t;

  localparam count_t MOD_MAX = count_t'(MOD - 1);

  function automatic logic legal(count_t v);
    return v <= MOD_MAX;
  endfunction

endpackage

// File: rtl/modport_counter_next.sv
// modport_counter_next: purely combinational next-value logic.
// Ports:
//   count      in  WIDTH  current registered count
//   load       in  1      1 = take data_in (clamped to 0 when out of range)
//   data_in    in  WIDTH  parallel load value
//   upd        in  1      1 = count up, 0 = count down
//   next_count out WIDTH  value to register on the next edge
module modport_counter_next
  import counter_pkg::*;
(
  input  logic [WIDTH-1:0] count,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             upd,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH:0] MOD_MAX_EXT = {1'b0, MOD_MAX};

  logic [WIDTH:0] up_ext;
  logic [WIDTH:0] dn_ext;

  // One spare bit so wrap is detected explicitly rather than by 2**WIDTH overflow.
  assign up_ext = {1'b0, count} + (WIDTH + 1)'(1);
  assign dn_ext = {1'b0, count} - (WIDTH + 1)'(1);

  always_comb begin
    next_count = '0;
    if (load) begin
      next_count = legal(data_in) ? data_in : '0;
    end else if (!legal(count)) begin
      // Recovery from a forced/corrupted out-of-range value.
      next_count = '0;
    end else if (upd) begin
      next_count = (up_ext > MOD_MAX_EXT) ? '0 : up_ext[WIDTH-1:0];
    end else begin
      // Borrow into the spare bit means count was 0.
      next_count = dn_ext[WIDTH] ? MOD_MAX : dn_ext[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/modport_counter.sv
// modport_counter: loadable synchronous up/down modulo-MOD counter.
// Ports:
//   clock   in  1      sole clock, all updates on posedge
//   reset   in  1      synchronous active-high clear, overrides everything
//   load    in  1      1 = load data_in this edge (upd ignored)
//   data_in in  WIDTH  load value, values >= MOD load as 0
//   upd     in  1      direction: 1 = up, 0 = down
//   count   out WIDTH  registered count, always in 0..MOD-1 after reset
module modport_counter
  import counter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             upd,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  modport_counter_next u_next (
    .count      (count_q),
    .load       (load),
    .data_in    (data_in),
    .upd        (upd),
    .next_count (count_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_modport_counter.sv
module tb_modport_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       upd = 1'b0;
  logic [3:0] count;

  int n_checks = 0;
  int n_pass = 0;

  int  model = 0;
  bit  model_valid = 1'b0;
  bit  done = 1'b0;

  modport_counter dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .upd     (upd),
    .count   (count)
  );

  always #5 clock = ~clock;

  // Reference model: plain modulo arithmetic on an int.
  always @(posedge clock) begin
    if (reset) begin
      model = 0;
      model_valid = 1'b1;
    end else if (load) begin
      model = (int'(data_in) < 12) ? int'(data_in) : 0;
    end else if (upd) begin
      model = (model + 1) % 12;
    end else begin
      model = (model + 11) % 12;
    end
  end

  // Every-cycle scoreboard, sampled mid-cycle away from the active edge.
  always @(negedge clock) begin
    if (model_valid && !done) begin
      n_checks++;
      if (count !== 4'(model) || count >= 4'd12) begin
        $display("FAIL scoreboard t=%0t count=%0d model=%0d", $time, count, model);
      end else begin
        n_pass++;
      end
    end
  end

  // Apply inputs (we sit 1 unit after an edge), cross one edge, check literal.
  task automatic cyc(input logic r, input logic l, input logic [3:0] d,
                     input logic u, input int exp, input string name);
    reset = r; load = l; data_in = d; upd = u;
    @(posedge clock);
    #1;
    n_checks++;
    if (count !== 4'(exp)) begin
      $display("FAIL %s count=%0d expected=%0d", name, count, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    cyc(1, 1, 4'd7, 1, 0, "reset_hold1");
    cyc(1, 1, 4'd7, 1, 0, "reset_hold2");
    cyc(0, 0, 4'd0, 1, 1, "post_reset_up1");
    cyc(0, 0, 4'd0, 1, 2, "post_reset_up2");
    cyc(0, 0, 4'd0, 1, 3, "post_reset_up3");

    cyc(0, 1, 4'd10, 1, 10, "load10");
    cyc(0, 0, 4'd0, 1, 11, "up_to11");
    cyc(0, 0, 4'd0, 1, 0, "up_wrap0");
    cyc(0, 0, 4'd0, 1, 1, "up_after_wrap");

    cyc(0, 1, 4'd1, 0, 1, "load1");
    cyc(0, 0, 4'd0, 0, 0, "down_to0");
    cyc(0, 0, 4'd0, 0, 11, "down_wrap11");
    cyc(0, 0, 4'd0, 0, 10, "down_after_wrap");

    cyc(0, 1, 4'd13, 1, 0, "clamp13");
    cyc(0, 1, 4'd15, 0, 0, "clamp15");
    cyc(0, 1, 4'd12, 1, 0, "clamp12");
    cyc(0, 1, 4'd11, 0, 11, "load11");
    cyc(0, 1, 4'd3, 1, 3, "load_beats_wrap");

    cyc(1, 1, 4'd5, 1, 0, "prio_reset");
    cyc(0, 1, 4'd5, 0, 5, "prio_load");
    cyc(0, 0, 4'd5, 0, 4, "prio_count_down");
    cyc(0, 0, 4'd0, 1, 5, "dir_up");
    cyc(0, 0, 4'd0, 0, 4, "dir_down");
    cyc(1, 0, 4'd0, 1, 0, "reset_midcount");

    for (int i = 0; i < 1000; i++) begin
      reset   = ($urandom_range(0, 15) == 0);
      load    = ($urandom_range(0, 3) == 0);
      data_in = 4'($urandom_range(0, 15));
      upd     = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end

    @(negedge clock);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
